// File: rtl/adc_channel_scheduler.sv
// Master controller for an 8-channel serial ADC: round-robin channel addressing,
// 16-SCLK frame generation and pipelined capture of tagged 12-bit conversions.
module adc_channel_scheduler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned QUIET_CLKS = 8
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        enable,
    input  logic [7:0]  channelMask,
    input  logic        adcDataOut,
    output logic        adcSerialClock,
    output logic        syncADC,
    output logic        adcDataIn,
    output logic [11:0] sampleData,
    output logic [2:0]  sampleChannel,
    output logic        sampleValid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FRAME, QUIET} stateT;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CLKS - 1);

    stateT       state, nextState;
    logic [7:0]  divCount;
    logic [5:0]  halfCount;
    logic [7:0]  quietCount;
    logic [2:0]  currentChannel;
    logic [2:0]  previousChannel;
    logic [2:0]  selectedChannel;
    logic [2:0]  candidate;
    logic        found;
    logic        primed;
    logic [11:0] shiftData;

    logic        runRequest;
    logic        startFrame;
    logic        goIdle;
    logic        halfTick;
    logic        fallEdge;
    logic        riseEdge;
    logic        endFrame;
    logic [5:0]  halfIndex;
    logic [3:0]  fallBit;
    logic [4:0]  riseBit;
    logic        frameBit;

    assign runRequest = enable && (channelMask != '0);
    assign busy       = (state != IDLE);

    // halfIndex n marks the clock at T0 + n*CLK_DIV: odd n falls SCLK, even n raises it, 33 ends the frame
    always_comb begin
        halfTick  = (state == FRAME) && (divCount == DIV_LAST);
        halfIndex = halfCount + 6'd1;
        fallEdge  = halfTick && halfIndex[0] && (halfIndex != 6'd33);
        riseEdge  = halfTick && !halfIndex[0];
        endFrame  = halfTick && (halfIndex == 6'd33);
        fallBit   = halfIndex[4:1];
        riseBit   = halfIndex[5:1] - 5'd1;
    end

    always_comb begin
        case (fallBit)
            4'd2:    frameBit = currentChannel[2];
            4'd3:    frameBit = currentChannel[1];
            4'd4:    frameBit = currentChannel[0];
            default: frameBit = 1'b0;
        endcase
    end

    // Next enabled channel above the current one, wrapping; offset 8 lands back on itself
    always_comb begin
        selectedChannel = currentChannel;
        candidate       = currentChannel;
        found           = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            candidate = currentChannel + 3'(i);
            if (!found && channelMask[candidate]) begin
                selectedChannel = candidate;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        nextState  = state;
        startFrame = 1'b0;
        goIdle     = 1'b0;
        case (state)
            IDLE: begin
                if (runRequest) begin
                    nextState  = FRAME;
                    startFrame = 1'b1;
                end
            end
            FRAME: begin
                if (endFrame) nextState = QUIET;
            end
            QUIET: begin
                if (quietCount == QUIET_LAST) begin
                    if (runRequest) begin
                        nextState  = FRAME;
                        startFrame = 1'b1;
                    end else begin
                        nextState = IDLE;
                        goIdle    = 1'b1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= nextState;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            adcSerialClock  <= 1'b1;
            syncADC         <= 1'b1;
            adcDataIn       <= 1'b0;
            sampleData      <= '0;
            sampleChannel   <= '0;
            sampleValid     <= 1'b0;
            divCount        <= '0;
            halfCount       <= '0;
            quietCount      <= '0;
            currentChannel  <= 3'd7;
            previousChannel <= 3'd7;
            primed          <= 1'b0;
            shiftData       <= '0;
        end else begin
            sampleValid <= 1'b0;

            if (startFrame) begin
                divCount        <= '0;
                halfCount       <= '0;
                syncADC         <= 1'b0;
                previousChannel <= currentChannel;
                currentChannel  <= selectedChannel;
            end else if (state == FRAME) begin
                if (halfTick) begin
                    divCount  <= '0;
                    halfCount <= halfIndex;
                end else begin
                    divCount <= divCount + 8'd1;
                end
            end

            if (fallEdge) begin
                adcSerialClock <= 1'b0;
                adcDataIn      <= frameBit;
            end

            if (riseEdge) begin
                adcSerialClock <= 1'b1;
                if (riseBit >= 5'd4) shiftData <= {shiftData[10:0], adcDataOut};
            end

            // Data shifted in this frame belongs to the channel addressed in the previous frame
            if (endFrame) begin
                syncADC    <= 1'b1;
                adcDataIn  <= 1'b0;
                quietCount <= '0;
                primed     <= 1'b1;
                if (primed) begin
                    sampleData    <= shiftData;
                    sampleChannel <= previousChannel;
                    sampleValid   <= 1'b1;
                end
            end

            if (state == QUIET) quietCount <= quietCount + 8'd1;
            if (goIdle)         primed     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler with a behavioural pipelined ADC
// and a frame monitor measuring sync low/high times and sample pulses.
module tb_adc_channel_scheduler;

    logic        clock = 1'b0;
    logic        resetN;
    logic        enable;
    logic [7:0]  channelMask;
    logic        adcDataOut = 1'b0;
    logic        adcSerialClock;
    logic        syncADC;
    logic        adcDataIn;
    logic [11:0] sampleData;
    logic [2:0]  sampleChannel;
    logic        sampleValid;
    logic        busy;

    int errorCount = 0;
    int checkCount = 0;

    adc_channel_scheduler #(.CLK_DIV(2), .QUIET_CLKS(8)) dut (
        .clock          (clock),
        .resetN         (resetN),
        .enable         (enable),
        .channelMask    (channelMask),
        .adcDataOut     (adcDataOut),
        .adcSerialClock (adcSerialClock),
        .syncADC        (syncADC),
        .adcDataIn      (adcDataIn),
        .sampleData     (sampleData),
        .sampleChannel  (sampleChannel),
        .sampleValid    (sampleValid),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Behavioural ADC: outputs the conversion of the channel addressed in the previous frame
    logic [11:0] chVal [8];
    logic [15:0] outWord = '0;
    logic [15:0] dinWord = '0;
    logic [2:0]  pendingChannel = '0;
    logic        prevSyncM = 1'b1;
    logic        prevSclk  = 1'b1;
    int          bitPos = 16;
    logic [2:0]  addrQ [$];
    logic [15:0] dinQ [$];

    always @(negedge clock) begin
        if (prevSyncM && !syncADC) begin
            outWord = {4'b0000, chVal[pendingChannel]};
            dinWord = '0;
            bitPos  = 0;
        end
        if (!syncADC && prevSclk && !adcSerialClock && bitPos < 16)
            adcDataOut = outWord[15 - bitPos];
        if (!syncADC && !prevSclk && adcSerialClock && bitPos < 16) begin
            dinWord[15 - bitPos] = adcDataIn;
            bitPos = bitPos + 1;
        end
        if (!prevSyncM && syncADC && resetN) begin
            pendingChannel = dinWord[13:11];
            addrQ.push_back(dinWord[13:11]);
            dinQ.push_back(dinWord);
        end
        prevSyncM = syncADC;
        prevSclk  = adcSerialClock;
    end

    int          lowRun = 0, highRun = 0, lastLow = 0, lastGap = 0;
    int          frameStarts = 0, frameEnds = 0, validCount = 0, gapViolations = 0;
    logic        prevSync = 1'b1;
    logic [11:0] lastData = '0;
    logic [2:0]  lastChan = '0;
    logic [2:0]  validChanQ [$];
    logic [11:0] validDataQ [$];

    always @(negedge clock) begin
        if (!syncADC) begin
            if (prevSync) begin
                lastGap     = highRun;
                frameStarts = frameStarts + 1;
                lowRun      = 0;
            end
            lowRun = lowRun + 1;
        end else begin
            if (!prevSync) begin
                lastLow   = lowRun;
                frameEnds = frameEnds + 1;
                highRun   = 0;
            end
            highRun = highRun + 1;
            if (adcSerialClock !== 1'b1 || adcDataIn !== 1'b0) gapViolations = gapViolations + 1;
        end
        if (sampleValid === 1'b1) begin
            validCount = validCount + 1;
            lastData   = sampleData;
            lastChan   = sampleChannel;
            validChanQ.push_back(sampleChannel);
            validDataQ.push_back(sampleData);
        end
        prevSync = syncADC;
    end

    task automatic checkEqual(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitFrameStart(input string tag);
        int   start;
        logic ok;
        start = frameStarts;
        ok    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (frameStarts != start) begin
                ok = 1'b1;
                break;
            end
        end
        checkEqual(tag, 32'(ok), 32'd1);
    endtask

    task automatic waitFrameEnd(input string tag);
        int   start;
        logic ok;
        start = frameEnds;
        ok    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (frameEnds != start) begin
                ok = 1'b1;
                break;
            end
        end
        checkEqual(tag, 32'(ok), 32'd1);
    endtask

    task automatic clearQueues();
        addrQ.delete();
        dinQ.delete();
        validChanQ.delete();
        validDataQ.delete();
    endtask

    int expAddr [5] = '{1, 3, 7, 1, 3};
    int expChan [4] = '{1, 3, 7, 1};
    int snapStarts;
    int snapValid;

    initial begin
        chVal[0] = 12'h0F1; chVal[1] = 12'h1E2; chVal[2] = 12'h2D3; chVal[3] = 12'h3C4;
        chVal[4] = 12'h4B5; chVal[5] = 12'hA5C; chVal[6] = 12'h697; chVal[7] = 12'h788;

        resetN      = 1'b0;
        enable      = 1'b0;
        channelMask = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        checkEqual("rstSync", 32'(syncADC), 32'd1);
        checkEqual("rstSclk", 32'(adcSerialClock), 32'd1);
        checkEqual("rstDin", 32'(adcDataIn), 32'd0);
        checkEqual("rstValid", 32'(sampleValid), 32'd0);
        checkEqual("rstBusy", 32'(busy), 32'd0);
        checkEqual("rstData", 32'(sampleData), 32'h000);
        @(negedge clock) resetN = 1'b1;
        repeat (2) @(posedge clock);
        clearQueues();

        // Single channel 5, CLK_DIV=2
        channelMask = 8'h20;
        enable      = 1'b1;
        waitFrameEnd("f1End");
        checkEqual("f1Low", 32'(lastLow), 32'd66);
        checkEqual("f1Din", 32'(dinQ[0]), 32'h2800);
        checkEqual("f1Valid", 32'(validCount), 32'd0);
        waitFrameEnd("f2End");
        checkEqual("f2Low", 32'(lastLow), 32'd66);
        checkEqual("f2Gap", 32'(lastGap), 32'd8);
        checkEqual("f2Valid", 32'(validCount), 32'd1);
        checkEqual("f2Data", 32'(lastData), 32'hA5C);
        checkEqual("f2Chan", 32'(lastChan), 32'd5);
        checkEqual("f2Addr", 32'(addrQ[1]), 32'd5);

        // Drop enable early in a primed frame
        waitFrameStart("f3Start");
        checkEqual("f3Gap", 32'(lastGap), 32'd8);
        repeat (3) @(posedge clock);
        enable = 1'b0;
        waitFrameEnd("f3End");
        checkEqual("f3Low", 32'(lastLow), 32'd66);
        checkEqual("f3Valid", 32'(validCount), 32'd2);
        repeat (12) @(posedge clock);
        #1;
        checkEqual("dropBusy", 32'(busy), 32'd0);
        snapStarts = frameStarts;
        repeat (100) @(posedge clock);
        checkEqual("dropNoRestart", 32'(frameStarts), 32'(snapStarts));
        checkEqual("dropValidOnce", 32'(validCount), 32'd2);
        checkEqual("gapClean", 32'(gapViolations), 32'd0);

        // Restart: first frame is a dummy
        enable = 1'b1;
        waitFrameEnd("reEnd");
        checkEqual("reDummy", 32'(validCount), 32'd2);

        // Asynchronous reset mid-frame
        waitFrameStart("rstFrameStart");
        repeat (18) @(posedge clock);
        #3;
        resetN = 1'b0;
        #1;
        checkEqual("midSync", 32'(syncADC), 32'd1);
        checkEqual("midSclk", 32'(adcSerialClock), 32'd1);
        checkEqual("midDin", 32'(adcDataIn), 32'd0);
        checkEqual("midBusy", 32'(busy), 32'd0);
        checkEqual("midData", 32'(sampleData), 32'h000);
        enable = 1'b0;
        @(negedge clock) resetN = 1'b1;
        snapStarts = frameStarts;
        repeat (50) @(posedge clock);
        #1;
        checkEqual("postRstIdle", 32'(frameStarts), 32'(snapStarts));
        checkEqual("postRstBusy", 32'(busy), 32'd0);
        checkEqual("postRstSync", 32'(syncADC), 32'd1);

        // Rotation over channels 1, 3, 7
        clearQueues();
        channelMask = 8'h8A;
        enable      = 1'b1;
        for (int i = 0; i < 5; i++) waitFrameEnd($sformatf("rotEnd%0d", i));
        enable = 1'b0;
        checkEqual("rotAddrCount", 32'(addrQ.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            checkEqual($sformatf("rotAddr%0d", i), 32'(addrQ[i]), 32'(expAddr[i]));
        checkEqual("rotValidCount", 32'(validChanQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkEqual($sformatf("rotChan%0d", i), 32'(validChanQ[i]), 32'(expChan[i]));
            checkEqual($sformatf("rotData%0d", i), 32'(validDataQ[i]), 32'(chVal[expChan[i]]));
        end
        repeat (30) @(posedge clock);

        // Mask change mid-frame takes effect at the next frame
        clearQueues();
        snapValid   = validCount;
        channelMask = 8'h01;
        enable      = 1'b1;
        waitFrameStart("mcStart");
        repeat (8) @(posedge clock);
        channelMask = 8'h04;
        waitFrameEnd("mcEnd0");
        waitFrameEnd("mcEnd1");
        enable = 1'b0;
        checkEqual("mcAddr0", 32'(addrQ[0]), 32'd0);
        checkEqual("mcAddr1", 32'(addrQ[1]), 32'd2);
        checkEqual("mcValidCount", 32'(validCount - snapValid), 32'd1);
        checkEqual("mcChan", 32'(validChanQ[0]), 32'd0);
        checkEqual("mcData", 32'(validDataQ[0]), 32'h0F1);
        repeat (30) @(posedge clock);
        checkEqual("finalGapClean", 32'(gapViolations), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
